// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU data port and a
// debug/loader master: CPU priority, bounded debug starvation, registered read return.
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          cpu_stall,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    o_dbg_owner,
   output logic [3:0]    o_dbg_wait_cnt
);

   // Handshake: req/we/addr/wdata are held stable by the requester until it sees
   // gnt high in the same cycle; the access is issued in that cycle, and a read
   // returns rvalid (one-cycle pulse) with rdata in the following cycle.

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

   localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

   owner_t          r_owner;
   owner_t          w_owner_nxt;
   logic [3:0]      r_wait_cnt;
   logic            r_rpend;
   logic            r_rsel;
   logic [DW-1:0]   r_rdata;

   logic            w_d_gnt;
   logic            w_c_gnt;
   logic            w_rd_issue;

   // Grants are masked while reset is low so no RAM access leaks out during reset.
   assign w_d_gnt    = reset & d_req & (~c_req | (r_wait_cnt >= LP_MAX_WAIT));
   assign w_c_gnt    = reset & c_req & ~w_d_gnt;
   assign w_rd_issue = (w_c_gnt & ~c_we) | (w_d_gnt & ~d_we);

   assign c_gnt     = w_c_gnt;
   assign d_gnt     = w_d_gnt;
   assign cpu_stall = c_req & ~w_c_gnt;

   assign mem_we    = (w_c_gnt & c_we) | (w_d_gnt & d_we);
   assign mem_addr  = w_d_gnt ? d_addr  : (w_c_gnt ? c_addr  : '0);
   assign mem_wdata = w_d_gnt ? d_wdata : (w_c_gnt ? c_wdata : '0);

   assign c_rvalid = reset & r_rpend & ~r_rsel;
   assign d_rvalid = reset & r_rpend & r_rsel;
   assign c_rdata  = r_rdata;
   assign d_rdata  = r_rdata;

   assign o_dbg_owner    = r_owner;
   assign o_dbg_wait_cnt = r_wait_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_owner <= OWN_IDLE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_owner_nxt = OWN_IDLE;
      if (w_d_gnt) begin
         w_owner_nxt = OWN_DBG;
      end else if (w_c_gnt) begin
         w_owner_nxt = OWN_CPU;
      end
   end

   // Counts consecutive cycles in which a debug request was denied.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wait_cnt <= 4'd0;
      end else if (!d_req || w_d_gnt) begin
         r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != 4'd15) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rpend <= 1'b0;
         r_rsel  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_rpend <= w_rd_issue;
         if (w_rd_issue) begin
            r_rsel  <= w_d_gnt;
            r_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_dmem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid, cpu_stall, mem_we;
  logic [DW-1:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    o_dbg_owner;
  logic [3:0]    o_dbg_wait_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .cpu_stall(cpu_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .o_dbg_owner(o_dbg_owner), .o_dbg_wait_cnt(o_dbg_wait_cnt)
  );

  // ---------------- RAM environment ----------------
  logic [DW-1:0] ram [0:255];
  logic          ram_load = 1'b1;

  assign mem_rdata = ram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 32'h20) ? 32'h1234_5678 : 32'h0;
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [DW:0]   exp_q[$];        // {is_debug, data} of the read issued last cycle
  logic [DW-1:0] m_mem [0:255];
  logic [DW-1:0] m_rdata = '0;
  int            m_denied = 0;    // consecutive denied debug cycles
  int            m_last_owner = 0; // 0 none, 1 cpu, 2 debug
  bit            model_init = 1'b1;

  always @(negedge clk) begin
    bit            e_dg, e_cg, e_crv, e_drv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            e_we;
    logic [DW:0]   ent;

    if (model_init) begin
      for (int i = 0; i < 256; i++) m_mem[i] = (i == 32'h20) ? 32'h1234_5678 : 32'h0;
      model_init = 1'b0;
    end

    e_dg = reset && d_req && (!c_req || m_denied >= MAX_WAIT);
    e_cg = reset && c_req && !e_dg;
    e_we = (e_cg && c_we) || (e_dg && d_we);
    e_addr  = e_dg ? d_addr  : (e_cg ? c_addr  : '0);
    e_wdata = e_dg ? d_wdata : (e_cg ? c_wdata : '0);
    e_crv = 0;
    e_drv = 0;
    if (reset && exp_q.size() != 0) begin
      ent   = exp_q[0];
      e_drv = ent[DW];
      e_crv = !ent[DW];
    end

    chk("c_gnt", c_gnt, e_cg);
    chk("d_gnt", d_gnt, e_dg);
    chk("cpu_stall", cpu_stall, c_req && !e_cg);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("c_rvalid", c_rvalid, e_crv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("c_rdata", c_rdata, m_rdata);
    chk("d_rdata", d_rdata, m_rdata);
    chk("owner", o_dbg_owner, m_last_owner);
    chk("wait_cnt", o_dbg_wait_cnt, (m_denied > 15) ? 15 : m_denied);

    // advance the model to the state after the coming rising edge
    exp_q.delete();
    if (!reset) begin
      m_denied     = 0;
      m_rdata      = '0;
      m_last_owner = 0;
    end else begin
      m_denied     = (!d_req || e_dg) ? 0 : ((m_denied < 15) ? m_denied + 1 : 15);
      m_last_owner = e_dg ? 2 : (e_cg ? 1 : 0);
      if ((e_cg || e_dg) && !e_we) begin
        m_rdata = m_mem[e_addr[7:0]];
        exp_q.push_back({e_dg, m_rdata});
      end
      if (e_we) m_mem[e_addr[7:0]] = e_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst,
                      input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                      input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd);
    @(posedge clk);
    #1;
    reset = rst;
    c_req = creq; c_we = cwe; c_addr = caddr; c_wdata = cwd;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwd;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic rst);
    step(rst, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got_c, got_d;
    reset = 1'b0;
    c_req = 1; c_we = 0; c_addr = 32'h10; c_wdata = 0;
    d_req = 1; d_we = 0; d_addr = 32'h20; d_wdata = 0;
    @(posedge clk);
    #1 ram_load = 1'b0;

    // reset with both requesting
    @(negedge clk);
    #1;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    step(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", {c_rvalid, d_rvalid}, 0);
    chk("rst_rdata", c_rdata, 0);

    // CPU alone: write then read back
    step(1, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("cw_gnt", c_gnt, 1);
    chk("cw_stall", cpu_stall, 0);
    chk("cw_we", mem_we, 1);
    step(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("cr_gnt", c_gnt, 1);
    chk("cr_stall", cpu_stall, 0);
    idle(1);
    chk("cr_rvalid", c_rvalid, 1);
    chk("cr_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("cr_d_rvalid", d_rvalid, 0);

    // debug alone: preloaded word
    step(1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    chk("dr_gnt", d_gnt, 1);
    idle(1);
    chk("dr_rvalid", d_rvalid, 1);
    chk("dr_rdata", d_rdata, 32'h1234_5678);
    chk("dr_c_rvalid", c_rvalid, 0);

    // contention: 10 cycles, expect C,C,C,C,D repeating
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      chk("con_d_gnt", d_gnt, (i % 5) == 4);
      chk("con_c_gnt", c_gnt, (i % 5) != 4);
      chk("con_stall", cpu_stall, (i % 5) == 4);
      chk("con_wait", o_dbg_wait_cnt, i % 5);
    end
    idle(1);

    // back-to-back mixed reads
    step(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("b2b_c_gnt", c_gnt, 1);
    step(1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    chk("b2b_d_gnt", d_gnt, 1);
    chk("b2b_c_rvalid", c_rvalid, 1);
    chk("b2b_c_rdata", c_rdata, 32'hDEAD_BEEF);
    idle(1);
    chk("b2b_d_rvalid", d_rvalid, 1);
    chk("b2b_d_rdata", d_rdata, 32'h1234_5678);
    chk("b2b_c_rvalid2", c_rvalid, 0);

    // reset in the cycle after a granted read
    step(1, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    chk("rmr_gnt", c_gnt, 1);
    idle(0);
    chk("rmr_rvalid", c_rvalid, 0);
    idle(0);
    idle(1);
    chk("rmr_rdata", c_rdata, 0);
    chk("rmr_rvalid2", c_rvalid, 0);
    chk("rmr_owner", o_dbg_owner, 0);
    step(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("rmr_gnt2", c_gnt, 1);
    idle(1);
    chk("rmr_rvalid3", c_rvalid, 1);
    chk("rmr_rdata2", c_rdata, 32'hDEAD_BEEF);

    // random traffic; requests held until granted
    got_c = 1; got_d = 1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 199) != 0);
      if (!c_req || got_c) begin
        c_req   = ($urandom_range(0, 9) < 7);
        c_we    = $urandom_range(0, 1);
        c_addr  = $urandom_range(0, 255);
        c_wdata = $urandom;
      end
      if (!d_req || got_d) begin
        d_req   = ($urandom_range(0, 9) < 4);
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom_range(0, 255);
        d_wdata = $urandom;
      end
      @(negedge clk);
      got_c = c_gnt;
      got_d = d_gnt;
    end
    idle(1);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
